button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Front-end conditioning stage for mechanical push-buttons and switches. Synchronises an asynchronous raw input, filters contact bounce and produces a clean debounced level.
- Also produces single-cycle press/release pulses.
- press_pulse drives the en input of the 4-bit up counter block, so one physical press gives exactly one increment.

Parameters:
- STABLE_CYCLES, 16: consecutive stable synchronised samples, beyond the first, needed to accept a new level. Legal range >= 2.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser. Legal range >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_in  input  1  raw button/switch input, asynchronous to clk, may bounce
- btn_level  output  1  debounced level, registered
- press_pulse  output  1  one-cycle strobe on an accepted 0->1 transition, registered
- release_pulse  output  1  one-cycle strobe on an accepted 1->0 transition, registered

Behaviour:
- Reset: clk is clock, rst is asynchronous, active-high.
  - All synchroniser flops = 0 and state = STABLE_LOW.
  - Stable counter = 0.
  - btn_level = 0, press_pulse = 0, release_pulse = 0.
- Synchroniser: SYNC_STAGES-deep shift register. The last stage output s is the only signal the FSM sees.
- Stable counter: width $clog2(STABLE_CYCLES). It is cleared on every entry to a WAIT state and never wraps; the terminal value is STABLE_CYCLES-1.
- FSM has 4 states:
  - STABLE_LOW: s=1 -> WAIT_HIGH and clear the counter. Otherwise stay.
  - WAIT_HIGH:
    - s=0 -> STABLE_LOW (bounce rejected, no pulse).
    - s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, with press_pulse=1 for the next cycle only.
    - Otherwise cnt++.
  - STABLE_HIGH: s=0 -> WAIT_LOW and clear the counter. Otherwise stay.
  - WAIT_LOW: mirror of WAIT_HIGH with s inverted.
    - s=1 -> STABLE_HIGH (no pulse).
    - s=0 at terminal count -> STABLE_LOW, with release_pulse=1 for one cycle.
- btn_level = 1 in STABLE_HIGH and WAIT_LOW, 0 otherwise. It is registered and changes in the same cycle as the corresponding pulse.
- Latency: btn_in is stable before clock edge 0 and held. btn_level and the pulse assert in the cycle after edge SYNC_STAGES+STABLE_CYCLES. With the defaults that is edge 18.
- Glitch rejection: any opposite s sample during WAIT aborts. Acceptance needs STABLE_CYCLES+1 consecutive equal s samples, counting the sample that left the STABLE state.
- press_pulse and release_pulse are never both 1. Each is high for exactly one cycle per accepted transition.
- btn_in held high through reset release: treated as a fresh press, so press_pulse fires after the full latency.
- Reset asserted mid-WAIT: the transition is aborted asynchronously and no pulse is emitted.
- A bounce that restarts the WAIT cycle gets a full new count, never a partial one.

Decomposition:
- Package debounce_pkg holds:
  - the typedef for the state enum (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW);
  - the localparam helper for the counter width.
- Sub-module synchronizer: parameterised N-stage, 1-bit, async reset to 0. It is reused elsewhere for other asynchronous inputs.

Test Plan:
- Clean press, defaults: btn_in 0->1 before edge 0, held 40 cycles.
  - btn_level and press_pulse go high after edge 18.
  - press_pulse is high for exactly 1 cycle; btn_level stays 1.
- Bouncy press: btn_in toggles 1,0,1,0 at 3-cycle intervals, then holds 1.
  - No press_pulse during the bounces.
  - Exactly one press_pulse, 18 cycles after the last 0->1 is sampled.
- Short glitch: btn_in high for 10 cycles, then low.
  - btn_level stays 0, and no pulse of either kind.
- Release: from the debounced-high state, btn_in 1->0 held.
  - release_pulse is high for 1 cycle and btn_level falls after 18 edges.
  - press_pulse stays 0.
- Reset mid-WAIT: assert rst 5 cycles after btn_in rises, then release with btn_in still 1.
  - Outputs are 0 immediately on rst.
  - press_pulse fires 18 edges after reset release.
- Counter integration: drive press_pulse into the 4-bit counter en and apply 17 bouncy presses.
  - count ends at 4'h1 (wrap-around), with no extra increments.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the push-button debouncer: the FSM state encoding and
// the helper that sizes the stable-sample counter.
// -----------------------------------------------------------------------------
package debounce_pkg;

  // STABLE_* states hold an accepted level; WAIT_* states are qualifying a
  // candidate new level. Bit 1 of the encoding equals the debounced level.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  // Counter must hold 0 .. stable_cycles-1. Never returns less than one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
// N-stage, 1-bit shift-register synchroniser for an asynchronous input.
// All stages clear to 0 on reset. Used by several front-end blocks.
//
// Ports:
//   clk  - destination clock
//   rst  - asynchronous, active-high reset
//   i_d  - asynchronous input
//   o_q  - synchronised output (last stage)
// -----------------------------------------------------------------------------
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Conditions a raw mechanical button/switch input: synchronises it, rejects
// contact bounce and produces a clean level plus one-cycle press/release
// strobes. press_pulse is meant to drive a counter enable directly.
//
// Ports:
//   clk           - system clock
//   rst           - asynchronous, active-high reset
//   btn_in        - raw input, asynchronous, may bounce
//   btn_level     - debounced level (registered)
//   press_pulse   - one-cycle strobe on an accepted 0->1 (registered)
//   release_pulse - one-cycle strobe on an accepted 1->0 (registered)
//
// state       | meaning
// ------------+-------------------------------------------------------------
// STABLE_LOW  | accepted level 0, watching for s=1
// WAIT_HIGH   | s went 1, counting consecutive 1 samples; any 0 aborts
// STABLE_HIGH | accepted level 1, watching for s=0
// WAIT_LOW    | s went 0, counting consecutive 0 samples; any 1 aborts
// -----------------------------------------------------------------------------
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_in),
    .o_q (w_s)
  );

  // The sample that moves us out of a STABLE state counts as the first of
  // the STABLE_CYCLES+1 required, so the counter starts at 0 on WAIT entry
  // and acceptance happens on the sample that finds it at the terminal value.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LOW;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = STABLE_HIGH;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = STABLE_HIGH;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt   = STABLE_LOW;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it moves in the same cycle
  // as the matching strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= STABLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == STABLE_HIGH) || (w_state_nxt == WAIT_LOW);
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

`ifndef SYNTHESIS
  a_pulses_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(press_pulse && release_pulse));
  a_press_one_cycle : assert property (
    @(posedge clk) disable iff (rst) press_pulse |=> !press_pulse);
  a_release_one_cycle : assert property (
    @(posedge clk) disable iff (rst) release_pulse |=> !release_pulse);
`endif

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  // btn_in driven just after negedge with the edge counter at c: edge 0 is
  // posedge c+1, outputs change on edge SYNC+STABLE = 18, i.e. posedge c+19.
  localparam int LAT = 19;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit is_press;
    int at;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] r_count;
  logic       cnt_clr;
  logic       prev_level = 1'b0;

  button_debouncer #(
    .STABLE_CYCLES(16),
    .SYNC_STAGES  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream 4-bit up counter with press_pulse as its enable.
  always @(posedge clk) begin
    if (cnt_clr) r_count <= 4'd0;
    else if (press_pulse) r_count <= r_count + 4'd1;
  end

  // Monitor: every strobe pops one expectation; level may only move with a strobe.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (press_pulse && release_pulse) begin
        total++; bad++;
        $display("FAIL both_pulses at cyc=%0d press=%0b release=%0b want not both", cyc, press_pulse, release_pulse);
      end else if (press_pulse || release_pulse) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse at cyc=%0d press=%0b release=%0b want none", cyc, press_pulse, release_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.is_press != press_pulse || e.at != cyc || btn_level != press_pulse) begin
            bad++;
            $display("FAIL pulse got press=%0b cyc=%0d level=%0b want press=%0b cyc=%0d level=%0b",
                     press_pulse, cyc, btn_level, e.is_press, e.at, e.is_press);
          end
        end
      end
      total++;
      if ((btn_level != prev_level) != (press_pulse || release_pulse)) begin
        bad++;
        $display("FAIL level_vs_pulse at cyc=%0d level=%0b prev=%0b pulses=%0b%0b want level change only with pulse",
                 cyc, btn_level, prev_level, press_pulse, release_pulse);
      end
    end
    prev_level = btn_level;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic expect_pulse(input bit is_press, input int at);
    exp_t e;
    e.is_press = is_press;
    e.at       = at;
    exp_q.push_back(e);
  endtask

  // Drive a settled level and queue the strobe it must produce.
  task automatic press_final();
    btn_in = 1'b1;
    expect_pulse(1'b1, cyc + LAT);
  endtask

  task automatic release_final();
    btn_in = 1'b0;
    expect_pulse(1'b0, cyc + LAT);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d want finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    btn_in  = 1'b0;
    cnt_clr = 1'b1;
    step(3);
    check("reset_level",   btn_level,     0);
    check("reset_press",   press_pulse,   0);
    check("reset_release", release_pulse, 0);
    rst     = 1'b0;
    cnt_clr = 1'b0;
    step(5);

    // Clean press, held 40 cycles.
    press_final();
    step(LAT - 1);
    check("clean_level_before", btn_level, 0);
    step(1);
    check("clean_press_at", press_pulse, 1);
    check("clean_level_at", btn_level, 1);
    step(1);
    check("clean_press_after", press_pulse, 0);
    check("clean_level_hold",  btn_level, 1);
    step(20);
    check("clean_queue", exp_q.size(), 0);

    // Release from debounced high.
    release_final();
    step(LAT - 1);
    check("release_level_before", btn_level, 1);
    step(1);
    check("release_pulse_at", release_pulse, 1);
    check("release_press_low", press_pulse, 0);
    check("release_level_at", btn_level, 0);
    step(20);
    check("release_queue", exp_q.size(), 0);

    // Bouncy press: 1,0,1,0 every 3 cycles, then hold 1.
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(3);
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(3);
    press_final();
    step(40);
    check("bouncy_level", btn_level, 1);
    check("bouncy_queue", exp_q.size(), 0);
    release_final();
    step(30);

    // Short glitch: 10 cycles high.
    btn_in = 1'b1; step(10);
    btn_in = 1'b0; step(30);
    check("glitch_level", btn_level, 0);
    check("glitch_queue", exp_q.size(), 0);

    // Reset while debounced high, btn_in held through release.
    press_final();
    step(25);
    rst = 1'b1;
    #1;
    check("rst_high_level_async", btn_level, 0);
    step(2);
    rst = 1'b0;
    expect_pulse(1'b1, cyc + LAT);
    step(25);
    check("rst_hold_high_level", btn_level, 1);
    release_final();
    step(25);

    // Reset mid-WAIT: 5 cycles after btn_in rises.
    btn_in = 1'b1;
    step(5);
    rst = 1'b1;
    #1;
    check("rst_wait_level",   btn_level,     0);
    check("rst_wait_press",   press_pulse,   0);
    check("rst_wait_release", release_pulse, 0);
    step(3);
    rst = 1'b0;
    expect_pulse(1'b1, cyc + LAT);
    step(LAT - 1);
    check("rst_wait_press_before", press_pulse, 0);
    step(1);
    check("rst_wait_press_at", press_pulse, 1);
    step(10);
    check("rst_wait_queue", exp_q.size(), 0);
    release_final();
    step(25);

    // 17 bouncy presses into the 4-bit counter.
    cnt_clr = 1'b1; step(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      btn_in = 1'b1; step(2);
      btn_in = 1'b0; step(2);
      press_final();  step(24);
      btn_in = 1'b0; step(2);
      btn_in = 1'b1; step(2);
      release_final(); step(24);
    end
    step(2);
    check("counter_wrap", r_count, 1);
    check("counter_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
